// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard scoreboard.
//   fwd_sel_t      - E-stage ALU operand source select
//   mdu_cnt_width  - width of the MDU busy down-counter for a given latency
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // The counter must hold MDU_LAT-1; $clog2(lat) bits suffice for lat >= 2.
    function automatic int mdu_cnt_width(input int lat);
        if (lat < 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(lat);
        end
    endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// mdu_busy_tracker: tracks occupancy of the multi-cycle multiply/divide unit.
//   clk   in  core clock
//   reset in  asynchronous, active-high; aborts tracking immediately
//   start in  mult/div issuing in E this cycle (reloads the counter)
//   busy  out MDU still producing HI/LO (registered)
module mdu_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam int CW = mdu_cnt_width(MDU_LAT);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(MDU_LAT - 32'sd1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          busy_r;

    // Next count: reload on issue, otherwise count down and park at zero.
    always_comb begin
        count_next_s = count_r;
        if (start) begin
            count_next_s = CNT_RELOAD;
        end else if (count_r != CNT_ZERO) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = CNT_ZERO;
        end
    end

    // Counter and busy flag; busy is registered from the next count so it equals (count != 0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            busy_r  <= (count_next_s != CNT_ZERO);
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard controller for the 5-stage MIPS pipeline.
//   Inputs : D/E source registers, E/M/W destination registers and write
//            enables, load flags in E/M, branch/jump/taken in D, MDU issue
//            in D/E, mfhi/mflo in D, stall-counter clear.
//   Outputs: forwardaD/forwardbD (branch bypass from M), forwardaE/forwardbE
//            (ALU operand select), stallF/stallD/flushD/flushE, mdubusy,
//            stallcnt (saturating count of stalled cycles).
// Hazard outputs are combinational from current inputs; mdubusy and
// stallcnt are registered.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REGBITS = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    input  logic [REGBITS-1:0] rsE,
    input  logic [REGBITS-1:0] rtE,
    input  logic [REGBITS-1:0] writeregE,
    input  logic [REGBITS-1:0] writeregM,
    input  logic [REGBITS-1:0] writeregW,
    input  logic               regwriteE,
    input  logic               regwriteM,
    input  logic               regwriteW,
    input  logic               memtoregE,
    input  logic               memtoregM,
    input  logic               branchD,
    input  logic               branchneD,
    input  logic               pcsrcD,
    input  logic               jumpD,
    input  logic               mdustartD,
    input  logic               mdustartE,
    input  logic               hiloreadD,
    input  logic               stallcntclr,
    output logic               forwardaD,
    output logic               forwardbD,
    output fwd_sel_t           forwardaE,
    output fwd_sel_t           forwardbE,
    output logic               stallF,
    output logic               stallD,
    output logic               flushD,
    output logic               flushE,
    output logic               mdubusy,
    output logic [CNT_W-1:0]   stallcnt
);

    localparam logic [REGBITS-1:0] REG_ZERO = {REGBITS{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    logic             rs_d_nz_s;
    logic             rt_d_nz_s;
    logic             lw_stall_s;
    logic             branch_stall_s;
    logic             mdu_stall_s;
    logic             stall_s;
    logic             mdu_busy_s;
    logic [CNT_W-1:0] stall_cnt_r;

    mdu_busy_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_busy_tracker (
        .clk   (clk),
        .reset (reset),
        .start (mdustartE),
        .busy  (mdu_busy_s)
    );

    assign rs_d_nz_s = (rsD != REG_ZERO);
    assign rt_d_nz_s = (rtD != REG_ZERO);

    // Branch comparator in D only needs the M-stage result; W is written back before D reads.
    assign forwardaD = rs_d_nz_s && (rsD == writeregM) && regwriteM;
    assign forwardbD = rt_d_nz_s && (rtD == writeregM) && regwriteM;

    // ALU operand A select: the younger M result wins over W.
    always_comb begin
        forwardaE = FWD_RF;
        if ((rsE != REG_ZERO) && (rsE == writeregM) && regwriteM) begin
            forwardaE = FWD_MEM;
        end else if ((rsE != REG_ZERO) && (rsE == writeregW) && regwriteW) begin
            forwardaE = FWD_WB;
        end else begin
            forwardaE = FWD_RF;
        end
    end

    // ALU operand B select: same priority as operand A.
    always_comb begin
        forwardbE = FWD_RF;
        if ((rtE != REG_ZERO) && (rtE == writeregM) && regwriteM) begin
            forwardbE = FWD_MEM;
        end else if ((rtE != REG_ZERO) && (rtE == writeregW) && regwriteW) begin
            forwardbE = FWD_WB;
        end else begin
            forwardbE = FWD_RF;
        end
    end

    assign lw_stall_s = memtoregE && (rtE != REG_ZERO) && ((rtE == rsD) || (rtE == rtD));

    // A branch must wait for an ALU result still in E, or a load result still in M.
    assign branch_stall_s = (branchD || branchneD) && (
        (regwriteE && ((rs_d_nz_s && (writeregE == rsD)) || (rt_d_nz_s && (writeregE == rtD)))) ||
        (memtoregM && ((rs_d_nz_s && (writeregM == rsD)) || (rt_d_nz_s && (writeregM == rtD)))));

    // HI/LO readers and new MDU ops wait for any in-flight MDU op, including one issuing now.
    assign mdu_stall_s = (hiloreadD || mdustartD) && (mdustartE || mdu_busy_s);

    assign stall_s = lw_stall_s || branch_stall_s || mdu_stall_s;

    assign stallD  = stall_s;
    assign stallF  = stall_s;
    assign flushE  = stall_s;
    assign flushD  = (pcsrcD || jumpD) && !stall_s;
    assign mdubusy = mdu_busy_s;

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (stallcntclr) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stallcnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
// (REGBITS=5, MDU_LAT=4, CNT_W=3).
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, branchneD, pcsrcD, jumpD;
    logic       mdustartD, mdustartE, hiloreadD, stallcntclr;
    logic       forwardaD, forwardbD;
    fwd_sel_t   forwardaE, forwardbE;
    logic       stallF, stallD, flushD, flushE, mdubusy;
    logic [2:0] stallcnt;

    int checks;
    int errors;

    hazard_scoreboard #(
        .REGBITS (5),
        .MDU_LAT (4),
        .CNT_W   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rsD         (rsD),
        .rtD         (rtD),
        .rsE         (rsE),
        .rtE         (rtE),
        .writeregE   (writeregE),
        .writeregM   (writeregM),
        .writeregW   (writeregW),
        .regwriteE   (regwriteE),
        .regwriteM   (regwriteM),
        .regwriteW   (regwriteW),
        .memtoregE   (memtoregE),
        .memtoregM   (memtoregM),
        .branchD     (branchD),
        .branchneD   (branchneD),
        .pcsrcD      (pcsrcD),
        .jumpD       (jumpD),
        .mdustartD   (mdustartD),
        .mdustartE   (mdustartE),
        .hiloreadD   (hiloreadD),
        .stallcntclr (stallcntclr),
        .forwardaD   (forwardaD),
        .forwardbD   (forwardbD),
        .forwardaE   (forwardaE),
        .forwardbE   (forwardbE),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushD      (flushD),
        .flushE      (flushE),
        .mdubusy     (mdubusy),
        .stallcnt    (stallcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing a new MDU op while the previous one is still busy is illegal flow.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(mdustartE && mdubusy)) else begin
                errors++;
                $error("FAIL mdu_reissue observed=busy_restart expected=no_restart");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; branchneD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
        mdustartD = 1'b0; mdustartE = 1'b0; hiloreadD = 1'b0; stallcntclr = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;
        #1;
        check("rst_mdubusy",  32'(mdubusy),   32'd0);
        check("rst_stallcnt", 32'(stallcnt),  32'd0);
        check("rst_stallD",   32'(stallD),    32'd0);
        check("rst_fwdaE",    32'(forwardaE), 32'(2'b00));
        #11;
        reset = 1'b0;
        tick();

        // E forwarding: M beats W, then W alone, then r0 never forwards.
        rsE = 5'd8; rtE = 5'd8; writeregM = 5'd8; writeregW = 5'd8;
        regwriteM = 1'b1; regwriteW = 1'b1;
        #1;
        check("fwdaE_mem", 32'(forwardaE), 32'(2'b10));
        check("fwdbE_mem", 32'(forwardbE), 32'(2'b10));
        regwriteM = 1'b0;
        #1;
        check("fwdaE_wb", 32'(forwardaE), 32'(2'b01));
        check("fwdbE_wb", 32'(forwardbE), 32'(2'b01));
        rsE = 5'd0;
        #1;
        check("fwdaE_r0", 32'(forwardaE), 32'(2'b00));
        check("fwdbE_wb2", 32'(forwardbE), 32'(2'b01));
        regwriteM = 1'b1; writeregM = 5'd9;
        #1;
        check("fwdbE_wb_m_miss", 32'(forwardbE), 32'(2'b01));
        check("nostall_fwd", 32'(stallD), 32'd0);
        tick();

        // Load-use stall and counter increment.
        idle_inputs();
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        #1;
        check("lw_stallD", 32'(stallD), 32'd1);
        check("lw_stallF", 32'(stallF), 32'd1);
        check("lw_flushE", 32'(flushE), 32'd1);
        check("lw_cnt_before", 32'(stallcnt), 32'd0);
        tick();
        idle_inputs();
        memtoregE = 1'b1; rtE = 5'd0; rsD = 5'd0;
        #1;
        check("lw_cnt_after", 32'(stallcnt), 32'd1);
        check("lw_r0_nostall", 32'(stallD), 32'd0);
        tick();
        check("cnt_hold", 32'(stallcnt), 32'd1);

        // Branch waits on E producer, then bypasses from M.
        idle_inputs();
        branchneD = 1'b1; rsD = 5'd3; regwriteE = 1'b1; writeregE = 5'd3;
        #1;
        check("br_stallE", 32'(stallD), 32'd1);
        tick();
        idle_inputs();
        branchneD = 1'b1; rsD = 5'd3; writeregM = 5'd3; regwriteM = 1'b1;
        #1;
        check("br_go", 32'(stallD), 32'd0);
        check("br_fwdaD", 32'(forwardaD), 32'd1);
        check("br_fwdbD", 32'(forwardbD), 32'd0);
        check("br_cnt", 32'(stallcnt), 32'd2);
        memtoregM = 1'b1;
        #1;
        check("br_stallM_load", 32'(stallD), 32'd1);
        memtoregM = 1'b0;
        tick();

        // Flush of D on jump/taken branch, suppressed by a stall.
        idle_inputs();
        jumpD = 1'b1;
        #1;
        check("jmp_flushD", 32'(flushD), 32'd1);
        check("jmp_flushE", 32'(flushE), 32'd0);
        tick();
        memtoregE = 1'b1; rtE = 5'd7; rtD = 5'd7;
        #1;
        check("jmp_lw_flushD", 32'(flushD), 32'd0);
        check("jmp_lw_flushE", 32'(flushE), 32'd1);
        tick();
        idle_inputs();
        pcsrcD = 1'b1;
        #1;
        check("pcsrc_flushD", 32'(flushD), 32'd1);
        check("pcsrc_cnt", 32'(stallcnt), 32'd3);
        tick();

        // MDU: issue at t with mfhi held in D -> stall t..t+3, busy t+1..t+3.
        idle_inputs();
        mdustartE = 1'b1; hiloreadD = 1'b1;
        #1;
        check("mdu_t0_stall", 32'(stallD), 32'd1);
        check("mdu_t0_busy", 32'(mdubusy), 32'd0);
        tick();
        mdustartE = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("mdu_t%0d_stall", i), 32'(stallD), 32'd1);
            check($sformatf("mdu_t%0d_busy", i), 32'(mdubusy), 32'd1);
            tick();
        end
        #1;
        check("mdu_t4_stall", 32'(stallD), 32'd0);
        check("mdu_t4_busy", 32'(mdubusy), 32'd0);
        check("mdu_cnt", 32'(stallcnt), 32'd7);
        tick();

        // Clear beats increment; then saturation at 7.
        idle_inputs();
        memtoregE = 1'b1; rtE = 5'd4; rsD = 5'd4; stallcntclr = 1'b1;
        #1;
        check("clr_stallD", 32'(stallD), 32'd1);
        tick();
        check("clr_cnt", 32'(stallcnt), 32'd0);
        stallcntclr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 3) check("sat_cnt3", 32'(stallcnt), 32'd3);
            if (i == 7) check("sat_cnt7", 32'(stallcnt), 32'd7);
        end
        check("sat_cnt10", 32'(stallcnt), 32'd7);

        // Reset during an MDU op aborts tracking immediately.
        idle_inputs();
        mdustartE = 1'b1;
        tick();
        mdustartE = 1'b0;
        #1;
        check("rstmdu_t1_busy", 32'(mdubusy), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rstmdu_busy", 32'(mdubusy), 32'd0);
        check("rstmdu_cnt", 32'(stallcnt), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rstmdu_after", 32'(mdubusy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is short, so anything this long is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the 5-stage MIPS core, parametrised in register-address width and multiply/divide latency. It generates D- and E-stage forwarding selects, load-use and branch stalls, and the E flush. It also adds the behaviour the single-cycle-ALU core never needed:
- a busy tracker for the multi-cycle multiply/divide unit (MDU) guarding HI/LO;
- jump/taken-branch flush of D;
- a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REGBITS, 5, register-address width (register count 2**REGBITS; register 0 hard-wired zero)
- MDU_LAT, 4, MDU latency in cycles from issue in E to HI/LO written; legal range ≥ 2
- CNT_W, 32, stall-counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- rsD, rtD, rsE, rtE  in  REGBITS each  source registers in D/E
- writeregE, writeregM, writeregW  in  REGBITS each  destination registers
- regwriteE, regwriteM, regwriteW  in  1 each  destination write enables
- memtoregE, memtoregM  in  1 each  load in E/M
- branchD, branchneD  in  1 each  beq/bne in D
- pcsrcD  in  1  branch resolved taken in D
- jumpD  in  1  jump in D
- mdustartD, mdustartE  in  1 each  mult/div instruction in D/E
- hiloreadD  in  1  mfhi/mflo in D
- stallcntclr  in  1  synchronous clear of stall counter
- forwardaD, forwardbD  out  1 each  branch-comparator bypass from M
- forwardaE, forwardbE  out  2 each  ALU operand select, type fwd_sel_t
- stallF, stallD, flushD, flushE  out  1 each
- mdubusy  out  1  MDU occupied
- stallcnt  out  CNT_W  stall-cycle count

## Operation
- **D-stage forwarding.** forwardaD = rsD≠0 & rsD==writeregM & regwriteM; forwardbD is the same with rtD.
- **E-stage forwarding.** For each operand (rsE→A, rtE→B), reg ≠ 0 required:
  - M match with regwriteM → FWD_MEM (10);
  - otherwise W match with regwriteW → FWD_WB (01);
  - otherwise FWD_RF (00). M has priority over W.
- **Load-use stall.** lwstall = memtoregE & rtE≠0 & (rtE==rsD | rtE==rtD).
- **Branch stall.** branchstall = (branchD|branchneD) & one of the following, with the compared D register ≠ 0:
  - regwriteE & writeregE matches rsD/rtD;
  - memtoregM & writeregM matches rsD/rtD.
- **MDU stall.** mdustall = (hiloreadD | mdustartD) & (mdustartE | mdubusy).
- **Stall and flush outputs.**
  - stallD = lwstall | branchstall | mdustall; stallF = stallD; flushE = stallD.
  - flushD = (pcsrcD | jumpD) & ~stallD.
- **MDU tracker.**
  - A down-counter of width $clog2(MDU_LAT). mdubusy = (count ≠ 0).
  - mdustartE loads MDU_LAT−1.
  - Otherwise the counter decrements while non-zero and holds at 0.
  - mdustartE while busy reloads. This is illegal in correct flow and is flagged by a bench assertion.
  - The counter runs regardless of stalls.
- **Stall counter.**
  - stallcntclr clears to 0; clear has priority over increment.
  - Otherwise it increments by 1 on each cycle stallD is high.
  - It saturates at 2**CNT_W−1.
- **Reset.** All outputs take their values from the following:
  - count = 0, so mdubusy = 0;
  - stallcnt = 0;
  - the combinational outputs follow their inputs.
  - Reset asserted mid-MDU operation aborts tracking immediately.

## Timing
- All hazard outputs are combinational from the current-cycle inputs; there are no modelled delays.
- mdustartE high in cycle t gives count = MDU_LAT−1 in t+1, reaching 0 in t+MDU_LAT. mdubusy is high in t+1 … t+MDU_LAT−1.
- An mfhi that is in D during cycle t stalls in cycles t … t+MDU_LAT−1 and advances at the edge ending t+MDU_LAT.
- stallcnt updates at the edge following each stalled cycle, so it is visible one cycle later.

## Structure
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - localparam function for counter width.
- Sub-module mdu_busy_tracker (clk, reset, start, busy), parametrised by MDU_LAT.
- Forwarding, stall logic and stall counter live in the top level.

## Test plan
- **E forwarding.** rsE=rtE=8, writeregM=writeregW=8, regwriteM=regwriteW=1 → forwardaE=forwardbE=10. Drop regwriteM → 01. rsE=0 → 00.
- **Load-use.** memtoregE=1, rtE=5, rsD=5 → stallD=stallF=flushE=1, stallcnt +1 next cycle. rtE=0 → no stall.
- **Branch.** branchneD=1, rsD=3, regwriteE=1, writeregE=3 → stallD=1. Next cycle, with writeregM=3, regwriteM=1, memtoregM=0 → stallD=0, forwardaD=1.
- **MDU, MDU_LAT=4.** mdustartE at t and hiloreadD held → stallD high t…t+3, low at t+4. mdubusy high exactly t+1…t+3.
- **Flush.** jumpD=1 with no stall → flushD=1. jumpD=1 and lwstall → flushD=0, flushE=1.
- **Counter and reset.**
  - CNT_W=3, stallD held 10 cycles → stallcnt saturates at 7.
  - stallcntclr with stallD=1 → 0.
  - reset asserted at t+2 of an MDU op → mdubusy=0 immediately.
